// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered, maskable, round-robin interrupt dispatcher with overrun tracking
// Ports: irqN active-low request lines; srcData packed per-source data words;
// maskWe/maskIn mask write; cpuAck dispatch acknowledge; ovClr overrun clear;
// cpuIrq/cpuIndex/cpuData current dispatch (index is source+1, 0 = none);
// pending/overrun per-source status flags.
module interrupt_controller #(
  parameter int NSRC = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        irqN,
  input  logic [NSRC*DATA_W-1:0] srcData,
  input  logic                   maskWe,
  input  logic [NSRC-1:0]        maskIn,
  input  logic                   cpuAck,
  input  logic                   ovClr,
  output logic                   cpuIrq,
  output logic [3:0]             cpuIndex,
  output logic [DATA_W-1:0]      cpuData,
  output logic [NSRC-1:0]        pending,
  output logic [NSRC-1:0]        overrun
);
  localparam int SW = NSRC > 1 ? $clog2(NSRC) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  state_t state, state_nx;
  logic [NSRC-1:0] irq_prev, armed, mask, fall, cand, clr;
  logic [DATA_W-1:0] hold_reg [NSRC];
  logic [SW-1:0] rr_ptr, sel, pick;
  logic found, ack;
  int idx;
  // armed stays low for a source that was held low through reset until it is seen high again
  assign fall = irq_prev & ~irqN & armed;
  assign cand = pending & ~mask;
  assign ack = state == ACTIVE && cpuAck;
  assign clr = ack ? NSRC'(1) << sel : '0;
  // lowest offset from rr_ptr wins, so scan offsets from the far end down
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (cand[idx]) begin
        pick = SW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? ACTIVE : IDLE) :
               state == ACTIVE ? (cpuAck ? GAP : ACTIVE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= '1;
      armed <= irqN;
      pending <= '0;
      overrun <= '0;
      mask <= '0;
      rr_ptr <= '0;
      sel <= '0;
      cpuIrq <= 1'b0;
      cpuIndex <= '0;
      cpuData <= '0;
      for (int i = 0; i < NSRC; i++) hold_reg[i] <= '0;
    end else begin
      irq_prev <= irqN;
      armed <= armed | irqN;
      // a fresh edge on the source being acknowledged re-pends it without counting as overrun
      pending <= (pending & ~clr) | fall;
      overrun <= (ovClr ? '0 : overrun) | (fall & pending & ~clr);
      if (maskWe) mask <= maskIn;
      for (int i = 0; i < NSRC; i++)
        if (fall[i]) hold_reg[i] <= srcData[i*DATA_W +: DATA_W];
      if (state == IDLE && found) begin
        sel <= pick;
        cpuIrq <= 1'b1;
        cpuIndex <= 4'(pick) + 4'd1;
        cpuData <= hold_reg[pick];
      end
      if (ack) begin
        rr_ptr <= sel == SW'(NSRC - 1) ? '0 : sel + 1'b1;
        cpuIrq <= 1'b0;
        cpuIndex <= '0;
      end
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scoreboard bench for interrupt_controller
module tb_interrupt_controller;
  logic clk = 1'b0, rst, maskWe, cpuAck, ovClr, cpuIrq;
  logic [3:0] irqN, maskIn, cpuIndex, pending, overrun;
  logic [63:0] srcData;
  logic [15:0] cpuData;
  int checks = 0, failures = 0;
  typedef enum {F_IRQ, F_IDX, F_DATA, F_PEND, F_OV} fld_t;
  typedef struct {fld_t f; logic [15:0] v; string tag;} exp_t;
  exp_t sb[$];

  interrupt_controller #(.NSRC(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .irqN(irqN), .srcData(srcData), .maskWe(maskWe),
    .maskIn(maskIn), .cpuAck(cpuAck), .ovClr(ovClr), .cpuIrq(cpuIrq),
    .cpuIndex(cpuIndex), .cpuData(cpuData), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] field(input fld_t f);
    return f == F_IRQ ? {15'b0, cpuIrq} : f == F_IDX ? {12'b0, cpuIndex} :
           f == F_DATA ? cpuData : f == F_PEND ? {12'b0, pending} : {12'b0, overrun};
  endfunction

  task automatic want(input fld_t f, input logic [15:0] v, input string tag);
    exp_t e;
    e.f = f;
    e.v = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [15:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = field(e.f);
      checks++;
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic want_zero(input string tag);
    want(F_IRQ, 16'h0, {tag, "_irq"});
    want(F_IDX, 16'h0, {tag, "_idx"});
    want(F_DATA, 16'h0, {tag, "_data"});
    want(F_PEND, 16'h0, {tag, "_pend"});
    want(F_OV, 16'h0, {tag, "_ov"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irqN = 4'hF; srcData = '0; maskWe = 1'b0; maskIn = '0; cpuAck = 1'b0; ovClr = 1'b0;
    tick();
    want_zero("reset");
    tick();
    rst = 1'b0;
    // single event
    srcData[15:0] = 16'h0041; irqN = 4'b1110;
    want(F_PEND, 16'h1, "t1_pend"); want(F_IRQ, 16'h0, "t1_latency");
    tick();
    want(F_IRQ, 16'h1, "t1_irq"); want(F_IDX, 16'h1, "t1_idx"); want(F_DATA, 16'h0041, "t1_data");
    tick();
    irqN = 4'hF; cpuAck = 1'b1;
    want(F_IRQ, 16'h0, "t1_ack_irq"); want(F_PEND, 16'h0, "t1_ack_pend");
    want(F_IDX, 16'h0, "t1_ack_idx"); want(F_DATA, 16'h0041, "t1_data_hold");
    tick();
    cpuAck = 1'b0;
    tick();
    // round-robin
    do_reset();
    irqN = 4'b1010; want(F_PEND, 16'h5, "t2_pend");
    tick();
    irqN = 4'hF; want(F_IRQ, 16'h1, "t2_irq_a"); want(F_IDX, 16'h1, "t2_idx_a");
    tick();
    cpuAck = 1'b1; want(F_PEND, 16'h4, "t2_ack_pend"); want(F_IRQ, 16'h0, "t2_ack_irq");
    tick();
    cpuAck = 1'b0; want(F_IRQ, 16'h0, "t2_gap");
    tick();
    want(F_IRQ, 16'h1, "t2_irq_b"); want(F_IDX, 16'h3, "t2_idx_b");
    tick();
    cpuAck = 1'b1; want(F_PEND, 16'h0, "t2_ack_b");
    tick();
    cpuAck = 1'b0;
    tick();
    irqN = 4'b1010; want(F_PEND, 16'h5, "t2_retrig");
    tick();
    irqN = 4'hF; want(F_IDX, 16'h1, "t2_wrap_first");
    tick();
    cpuAck = 1'b1;
    tick();
    cpuAck = 1'b0;
    tick();
    want(F_IDX, 16'h3, "t2_wrap_second");
    tick();
    cpuAck = 1'b1; want(F_PEND, 16'h0, "t2_done");
    tick();
    cpuAck = 1'b0;
    tick();
    // mask and overrun
    do_reset();
    maskWe = 1'b1; maskIn = 4'b0010;
    tick();
    maskWe = 1'b0; srcData[31:16] = 16'h0010; irqN = 4'b1101;
    want(F_PEND, 16'h2, "t3_masked_pend"); want(F_IRQ, 16'h0, "t3_masked_irq");
    tick();
    irqN = 4'hF;
    tick();
    srcData[31:16] = 16'h0020; irqN = 4'b1101;
    want(F_OV, 16'h2, "t3_overrun"); want(F_PEND, 16'h2, "t3_pend"); want(F_IRQ, 16'h0, "t3_still_masked");
    tick();
    irqN = 4'hF; maskWe = 1'b1; maskIn = 4'b0000;
    tick();
    maskWe = 1'b0;
    want(F_IRQ, 16'h1, "t3_unmask_irq"); want(F_IDX, 16'h2, "t3_idx"); want(F_DATA, 16'h0020, "t3_data");
    tick();
    ovClr = 1'b1; want(F_OV, 16'h0, "t3_ovclr");
    tick();
    srcData[31:16] = 16'h0030; irqN = 4'b1101;
    want(F_OV, 16'h2, "t3_ov_wins"); want(F_DATA, 16'h0020, "t3_active_data"); want(F_IDX, 16'h2, "t3_active_idx");
    tick();
    ovClr = 1'b0; irqN = 4'hF; cpuAck = 1'b1; want(F_PEND, 16'h0, "t3_ack_pend");
    tick();
    cpuAck = 1'b0;
    tick();
    // ack race
    do_reset();
    srcData[15:0] = 16'h0041; irqN = 4'b1110;
    tick();
    irqN = 4'hF; want(F_IRQ, 16'h1, "t4_irq"); want(F_DATA, 16'h0041, "t4_data");
    tick();
    srcData[15:0] = 16'h0055; irqN = 4'b1110; cpuAck = 1'b1;
    want(F_PEND, 16'h1, "t4_race_pend"); want(F_OV, 16'h0, "t4_race_ov"); want(F_IRQ, 16'h0, "t4_race_irq");
    tick();
    cpuAck = 1'b0; want(F_IRQ, 16'h0, "t4_gap");
    tick();
    want(F_IRQ, 16'h1, "t4_redispatch"); want(F_IDX, 16'h1, "t4_idx"); want(F_DATA, 16'h0055, "t4_new_data");
    tick();
    cpuAck = 1'b1;
    tick();
    cpuAck = 1'b0;
    tick();
    want(F_IRQ, 16'h0, "t4_held_irq"); want(F_PEND, 16'h0, "t4_held_pend");
    tick();
    // reset mid-active with source held low
    irqN = 4'hF;
    tick();
    irqN = 4'b1110; want(F_PEND, 16'h1, "t5_pend");
    tick();
    want(F_IRQ, 16'h1, "t5_active");
    tick();
    rst = 1'b1; want_zero("t5_rst");
    tick();
    rst = 1'b0;
    tick();
    tick();
    want(F_IRQ, 16'h0, "t5_held_irq"); want(F_PEND, 16'h0, "t5_held_pend");
    tick();
    irqN = 4'hF;
    tick();
    irqN = 4'b1110; want(F_PEND, 16'h1, "t5_refall_pend");
    tick();
    want(F_IRQ, 16'h1, "t5_irq"); want(F_IDX, 16'h1, "t5_idx"); want(F_DATA, 16'h0055, "t5_data");
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
